// File: rtl/time_set_ctrl_pkg.sv
// Shared types, limits and BCD helpers for the clock time-setting controller.
// Edit values are kept as two-digit BCD pairs so capture and increment stay per-field.
package time_set_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    SET_HR  = 2'd1,
    SET_MIN = 2'd2
  } state_t;

  localparam logic [6:0] HR_MAX       = 7'd23;
  localparam logic [3:0] MIN_TENS_MAX = 4'd5;
  localparam logic [3:0] DIGIT_MAX    = 4'd9;

  localparam logic [5:0] MASK_HR  = 6'b110000;
  localparam logic [5:0] MASK_MIN = 6'b001100;

  typedef struct packed {
    logic [3:0] d1;
    logic [3:0] d0;
  } bcd2_t;

  // Any malformed hour pair collapses to 00 so editing always starts from legal BCD.
  function automatic bcd2_t hr_sanitize(input bcd2_t v);
    logic [6:0] h;
    h = 7'(v.d1) * 7'd10 + 7'(v.d0);
    if (v.d1 > DIGIT_MAX || v.d0 > DIGIT_MAX || h > HR_MAX)
      return '0;
    return v;
  endfunction

  function automatic bcd2_t min_sanitize(input bcd2_t v);
    if (v.d1 > MIN_TENS_MAX || v.d0 > DIGIT_MAX)
      return '0;
    return v;
  endfunction

  function automatic bcd2_t hr_inc(input bcd2_t v);
    bcd2_t r;
    r = v;
    if (v.d1 == 4'd2 && v.d0 == 4'd3) begin
      r = '0;
    end else if (v.d0 == DIGIT_MAX) begin
      r.d1 = v.d1 + 4'd1;
      r.d0 = 4'd0;
    end else begin
      r.d0 = v.d0 + 4'd1;
    end
    return r;
  endfunction

  function automatic bcd2_t min_inc(input bcd2_t v);
    bcd2_t r;
    r = v;
    if (v.d0 == DIGIT_MAX) begin
      r.d0 = 4'd0;
      r.d1 = (v.d1 == MIN_TENS_MAX) ? 4'd0 : v.d1 + 4'd1;
    end else begin
      r.d0 = v.d0 + 4'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/time_set_ctrl_btn_debounce.sv
// Button conditioner: 2-flop synchroniser, tick-sampled debounce counter and
// a one-cycle press pulse on each accepted 0->1 level change.
module btn_debounce #(
  parameter int DB_CNT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  input  logic tick,
  output logic press
);

  localparam int CW = $clog2(DB_CNT + 1);

  logic [1:0]    sync_reg;
  logic [CW-1:0] cnt_reg;
  logic          level_reg;
  logic          press_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_reg  <= '0;
      cnt_reg   <= '0;
      level_reg <= 1'b0;
      press_reg <= 1'b0;
    end else begin
      sync_reg  <= {sync_reg[0], btn};
      press_reg <= 1'b0;
      if (tick) begin
        // A sample equal to the accepted level restarts the run of differing samples.
        if (sync_reg[1] == level_reg) begin
          cnt_reg <= '0;
        end else if (cnt_reg == CW'(DB_CNT - 1)) begin
          level_reg <= sync_reg[1];
          cnt_reg   <= '0;
          press_reg <= sync_reg[1];
        end else begin
          cnt_reg <= cnt_reg + 1'b1;
        end
      end
    end
  end

  assign press = press_reg;

endmodule

// File: rtl/time_set_ctrl.sv
// MODE/INC driven run / set-hours / set-minutes controller for the six-digit clock:
// run enable, one-shot parallel load of the edited time and a blink mask for the edited field.
module time_set_ctrl
  import time_set_ctrl_pkg::*;
#(
  parameter int DB_EXP    = 15,
  parameter int DB_CNT    = 4,
  parameter int BLINK_EXP = 23
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic [3:0] cur_hr1,
  input  logic [3:0] cur_hr0,
  input  logic [3:0] cur_min1,
  input  logic [3:0] cur_min0,
  output logic       ena,
  output logic       load,
  output logic [3:0] ld_hr1,
  output logic [3:0] ld_hr0,
  output logic [3:0] ld_min1,
  output logic [3:0] ld_min0,
  output logic [5:0] blink_mask
);

  localparam int DW = (DB_EXP > BLINK_EXP) ? DB_EXP : BLINK_EXP;

  logic [DW-1:0] div_reg;
  logic          tick;
  logic          blink_phase;
  logic [1:0]    raw_btn;
  logic [1:0]    press;
  logic          mode_press;
  logic          inc_press;

  state_t     state_reg, state_next;
  bcd2_t      eh_reg, eh_next, em_reg, em_next;
  bcd2_t      ldh_reg, ldh_next, ldm_reg, ldm_next;
  logic       ena_reg, ena_next, load_reg, load_next;
  logic [5:0] mask_reg, mask_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) div_reg <= '0;
    else     div_reg <= div_reg + 1'b1;
  end

  assign tick        = &div_reg[DB_EXP-1:0];
  assign blink_phase = div_reg[BLINK_EXP-1];
  assign raw_btn     = {btn_inc, btn_mode};

  for (genvar gi = 0; gi < 2; gi++) begin : g_btn
    btn_debounce #(.DB_CNT(DB_CNT)) u_db (
      .clk   (clk),
      .rst   (rst),
      .btn   (raw_btn[gi]),
      .tick  (tick),
      .press (press[gi])
    );
  end

  assign mode_press = press[0];
  assign inc_press  = press[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= RUN;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      RUN:     if (mode_press) state_next = SET_HR;
      SET_HR:  if (mode_press) state_next = SET_MIN;
      SET_MIN: if (mode_press) state_next = RUN;
      default: state_next = RUN;
    endcase
  end

  always_comb begin
    eh_next   = eh_reg;
    em_next   = em_reg;
    ldh_next  = ldh_reg;
    ldm_next  = ldm_reg;
    // The load cycle itself keeps ena low; run resumes one cycle later.
    ena_next  = (state_reg == RUN) && (state_next == RUN);
    load_next = 1'b0;
    mask_next = 6'b000000;
    if (state_reg == RUN && mode_press) begin
      eh_next = hr_sanitize({cur_hr1, cur_hr0});
      em_next = min_sanitize({cur_min1, cur_min0});
    end else if (state_reg == SET_MIN && mode_press) begin
      ldh_next  = eh_reg;
      ldm_next  = em_reg;
      load_next = 1'b1;
    end else if (inc_press && !mode_press) begin
      if (state_reg == SET_HR)  eh_next = hr_inc(eh_reg);
      if (state_reg == SET_MIN) em_next = min_inc(em_reg);
    end
    if (blink_phase) begin
      if (state_next == SET_HR)  mask_next = MASK_HR;
      if (state_next == SET_MIN) mask_next = MASK_MIN;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      eh_reg   <= '0;
      em_reg   <= '0;
      ldh_reg  <= '0;
      ldm_reg  <= '0;
      ena_reg  <= 1'b1;
      load_reg <= 1'b0;
      mask_reg <= '0;
    end else begin
      eh_reg   <= eh_next;
      em_reg   <= em_next;
      ldh_reg  <= ldh_next;
      ldm_reg  <= ldm_next;
      ena_reg  <= ena_next;
      load_reg <= load_next;
      mask_reg <= mask_next;
    end
  end

  assign ena        = ena_reg;
  assign load       = load_reg;
  assign ld_hr1     = ldh_reg.d1;
  assign ld_hr0     = ldh_reg.d0;
  assign ld_min1    = ldm_reg.d1;
  assign ld_min0    = ldm_reg.d0;
  assign blink_mask = mask_reg;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Self-checking bench for time_set_ctrl: directed scenarios plus randomized edit sessions
// compared against an hours/minutes arithmetic model.
module tb_time_set_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_mode = 1'b0;
  logic       btn_inc = 1'b0;
  logic [3:0] cur_hr1 = '0, cur_hr0 = '0, cur_min1 = '0, cur_min0 = '0;
  logic       ena, load;
  logic [3:0] ld_hr1, ld_hr0, ld_min1, ld_min0;
  logic [5:0] blink_mask;

  time_set_ctrl #(.DB_EXP(2), .DB_CNT(2), .BLINK_EXP(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_mode   (btn_mode),
    .btn_inc    (btn_inc),
    .cur_hr1    (cur_hr1),
    .cur_hr0    (cur_hr0),
    .cur_min1   (cur_min1),
    .cur_min0   (cur_min0),
    .ena        (ena),
    .load       (load),
    .ld_hr1     (ld_hr1),
    .ld_hr0     (ld_hr0),
    .ld_min1    (ld_min1),
    .ld_min0    (ld_min0),
    .blink_mask (blink_mask)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Model: 0=run, 1=editing hours, 2=editing minutes; time kept as plain integers.
  int mstate = 0;
  int mh = 0, mm = 0;
  int exp_loads = 0;
  int exp_ld [4] = '{0, 0, 0, 0};

  int load_cnt = 0;
  int cap [4] = '{0, 0, 0, 0};
  bit prev_load = 0;

  always @(negedge clk) begin
    if (rst) begin
      prev_load <= 0;
    end else begin
      if (load) begin
        load_cnt <= load_cnt + 1;
        cap <= '{int'(ld_hr1), int'(ld_hr0), int'(ld_min1), int'(ld_min0)};
        check("ena_in_load_cycle", int'(ena), 0);
      end
      if (prev_load) check("ena_after_load", int'(ena), 1);
      prev_load <= load;
    end
  end

  task automatic model_mode();
    int h, m;
    case (mstate)
      0: begin
        h = int'(cur_hr1) * 10 + int'(cur_hr0);
        m = int'(cur_min1) * 10 + int'(cur_min0);
        mh = (cur_hr1 <= 9 && cur_hr0 <= 9 && h <= 23) ? h : 0;
        mm = (cur_min1 <= 5 && cur_min0 <= 9) ? m : 0;
        mstate = 1;
      end
      1: mstate = 2;
      default: begin
        exp_loads++;
        exp_ld = '{mh / 10, mh % 10, mm / 10, mm % 10};
        mstate = 0;
      end
    endcase
  endtask

  task automatic model_inc();
    if (mstate == 1) mh = (mh + 1) % 24;
    if (mstate == 2) mm = (mm + 1) % 60;
  endtask

  task automatic press(input bit m, input bit i);
    @(posedge clk); #1;
    btn_mode = m; btn_inc = i;
    repeat (16) @(posedge clk); #1;
    btn_mode = 0; btn_inc = 0;
    repeat (16) @(posedge clk); #1;
  endtask

  task automatic check_state(input string tag);
    @(negedge clk);
    check({tag, "_ena"}, int'(ena), (mstate == 0) ? 1 : 0);
    check({tag, "_loads"}, load_cnt, exp_loads);
    case (mstate)
      0: begin
        check({tag, "_mask_run"}, int'(blink_mask), 0);
        check({tag, "_ld_hr1"}, int'(ld_hr1), exp_ld[0]);
        check({tag, "_ld_hr0"}, int'(ld_hr0), exp_ld[1]);
        check({tag, "_ld_min1"}, int'(ld_min1), exp_ld[2]);
        check({tag, "_ld_min0"}, int'(ld_min0), exp_ld[3]);
        check({tag, "_cap_hr"}, cap[0] * 10 + cap[1], exp_ld[0] * 10 + exp_ld[1]);
        check({tag, "_cap_min"}, cap[2] * 10 + cap[3], exp_ld[2] * 10 + exp_ld[3]);
      end
      1: check({tag, "_mask_hr_legal"}, int'(blink_mask == 6'b000000 || blink_mask == 6'b110000), 1);
      default: check({tag, "_mask_min_legal"}, int'(blink_mask == 6'b000000 || blink_mask == 6'b001100), 1);
    endcase
  endtask

  task automatic do_mode(input bit with_inc);
    press(1, with_inc);
    model_mode();
    check_state("mode");
  endtask

  task automatic do_inc();
    press(0, 1);
    model_inc();
  endtask

  task automatic set_cur(input int h1, input int h0, input int m1, input int m0);
    cur_hr1 = 4'(h1); cur_hr0 = 4'(h0); cur_min1 = 4'(m1); cur_min0 = 4'(m0);
  endtask

  int seq [64];

  initial begin
    // Reset state and idle run
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ena", int'(ena), 1);
    check("rst_load", int'(load), 0);
    check("rst_mask", int'(blink_mask), 0);
    check("rst_ld", int'({ld_hr1, ld_hr0, ld_min1, ld_min0}), 0);
    @(posedge clk); #1 rst = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      check("idle_ena", int'(ena), 1);
      check("idle_load", int'(load), 0);
      check("idle_mask", int'(blink_mask), 0);
    end

    // 14:37 edited through both wraps
    set_cur(1, 4, 3, 7);
    do_mode(0);
    for (int k = 0; k < 10; k++) do_inc();
    do_mode(0);
    for (int k = 0; k < 25; k++) do_inc();
    do_mode(0);
    check("dir_ld_hr", int'(ld_hr1) * 10 + int'(ld_hr0), 0);
    check("dir_ld_min", int'(ld_min1) * 10 + int'(ld_min0), 2);
    check("dir_load_count", load_cnt, 1);

    // One-tick MODE glitch is rejected, a two-tick hold is one event
    set_cur(0, 9, 5, 8);
    @(posedge clk); #1 btn_mode = 1;
    repeat (4) @(posedge clk); #1 btn_mode = 0;
    repeat (24) @(posedge clk); #1;
    check_state("glitch");
    @(posedge clk); #1 btn_mode = 1;
    repeat (8) @(posedge clk); #1 btn_mode = 0;
    repeat (24) @(posedge clk); #1;
    model_mode();
    check_state("two_tick");

    // Simultaneous MODE+INC in SET_HR: MODE wins, hours unchanged
    do_inc(); do_inc();
    do_mode(1);
    do_inc();
    do_mode(0);
    check("simul_ld_hr", int'(ld_hr1) * 10 + int'(ld_hr0), 11);
    check("simul_ld_min", int'(ld_min1) * 10 + int'(ld_min0), 59);

    // Blink phase in SET_MIN
    set_cur(2, 3, 5, 9);
    do_mode(0);
    do_mode(0);
    for (int c = 0; c < 64; c++) begin
      @(negedge clk);
      seq[c] = int'(blink_mask);
      check("blink_legal", int'(blink_mask == 6'b000000 || blink_mask == 6'b001100), 1);
      if (c >= 8) check("blink_alt", int'(seq[c] != 0), int'(seq[c-8] == 0));
    end

    // Reset mid-edit: back to RUN with no load pulse
    do_inc(); do_inc();
    @(negedge clk); #2 rst = 1;
    #1;
    check("midrst_ena", int'(ena), 1);
    check("midrst_load", int'(load), 0);
    check("midrst_ld", int'({ld_hr1, ld_hr0, ld_min1, ld_min0}), 0);
    check("midrst_mask", int'(blink_mask), 0);
    mstate = 0;
    exp_ld = '{0, 0, 0, 0};
    cap = '{0, 0, 0, 0};
    repeat (3) @(posedge clk); #1 rst = 0;
    repeat (40) @(posedge clk); #1;
    check_state("after_rst");

    // Randomized edit sessions, including out-of-range captures and INC while running
    for (int s = 0; s < 6; s++) begin
      int hv, mv;
      hv = $urandom_range(0, 23);
      mv = $urandom_range(0, 59);
      set_cur(hv / 10, hv % 10, mv / 10, mv % 10);
      if ($urandom_range(0, 2) == 0) cur_hr0 = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 2) == 0) cur_min1 = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 0) begin
        do_inc();
        check_state("rnd_run_inc");
      end
      do_mode(0);
      for (int k = $urandom_range(0, 12); k > 0; k--) do_inc();
      do_mode(1'($urandom_range(0, 1)));
      for (int k = $urandom_range(0, 12); k > 0; k--) do_inc();
      do_mode(1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/time_set_ctrl.md
Name: time_set_ctrl

Overview:
- Upstream control stage for the six-digit multiplexed clock. Debounces two raw push-buttons (MODE, INC) and runs a run/set-hours/set-minutes state machine.
- Drives the clock's run enable and a one-cycle parallel load of the BCD time digits.
- Supplies a per-digit blink mask so the display stage can flash the field being edited.

Parameters:
- DB_EXP, 15, button sample tick period = 2^DB_EXP clk cycles
- DB_CNT, 4, consecutive equal samples required to accept a new button level (1..15)
- BLINK_EXP, 23, blink phase toggles every 2^(BLINK_EXP-1) clk cycles (bit BLINK_EXP-1 of the free-running divider)

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- btn_mode  in  1  raw MODE button, asynchronous, active-high
- btn_inc  in  1  raw INC button, asynchronous, active-high
- cur_hr1, cur_hr0, cur_min1, cur_min0  in  4 each  live BCD counts from the clock counters
- ena  out  1  run enable to the seconds-units counter
- load  out  1  one-cycle pulse: clock counters take the ld_* values
- ld_hr1, ld_hr0, ld_min1, ld_min0  out  4 each  BCD load values (seconds are loaded as 0)
- blink_mask  out  6  bit i = 1 blanks digit i; 0 = sec units, 5 = hour tens

Behaviour:
- Reset (async, rst=1):
  - state=RUN, ena=1, load=0, all ld_*=0, blink_mask=0.
  - Edit registers, debounce state and dividers are cleared to 0.
- Input synchronisation: each button passes through a 2-flop synchroniser.
- Debounce:
  - Sample on tick (divider wrap, one pulse every 2^DB_EXP cycles).
  - The debounced level changes only after DB_CNT consecutive ticks sample the new value.
  - A press event is a 1-cycle pulse on a 0->1 debounced transition. Releases generate no event.
- State machine:
  - Sequence is RUN -> SET_HR -> SET_MIN -> RUN. Each advance happens on a MODE press event; there are no other transitions.
  - RUN -> SET_HR, same edge: capture cur_hr1, cur_hr0, cur_min1, cur_min0 into the edit registers (eh1, eh0, em1, em0); ena goes 0 on the next cycle.
  - SET_HR, INC event: hours advance in BCD, 00..23. 09->10 and 19->20; 23->00 wraps and does not touch minutes.
  - SET_MIN, INC event: minutes advance in BCD, 00..59. 09->10; 59->00 wraps with no carry into hours.
  - SET_MIN -> RUN, same edge:
    - ld_* = edit registers and load=1 for exactly that one following cycle.
    - ena=1 from the cycle after the load pulse.
- Simultaneous MODE and INC events in the same cycle: MODE wins; that INC event is discarded.
- Holding INC gives one increment only. There is no auto-repeat.
- INC events in RUN are ignored.
- ena:
  - 1 only in RUN.
  - 0 in both SET states, so seconds freeze while editing.
  - ena stays 0 during the load cycle itself.
- Blink mask:
  - blink_phase = divider bit BLINK_EXP-1.
  - SET_HR: mask = 6'b110000 when phase=1, else 0.
  - SET_MIN: mask = 6'b001100 when phase=1, else 0.
  - RUN: mask = 0.
- Edit values are always valid BCD:
  - If a captured value is out of range (hours >23, minute tens >5, or any digit >9), it is replaced by 0 at capture.
- Reset mid-edit: return to RUN with ena=1; no load pulse is issued.
- Outputs are registered, giving 1-cycle latency from the internal event to the output change.

Decomposition:
- Shared package holds:
  - state encoding: RUN=2'd0, SET_HR=2'd1, SET_MIN=2'd2
  - BCD limit constants: HR_MAX=23, MIN_TENS_MAX=5, DIGIT_MAX=9
  - mask constants: MASK_HR=6'b110000, MASK_MIN=6'b001100
- One natural sub-module, btn_debounce: synchroniser + sample counter + edge pulse, parameterised by DB_CNT, with its tick input fed by the parent's divider. It is instantiated twice.

Test Plan (all scenarios use DB_EXP=2, DB_CNT=2, BLINK_EXP=4):
- Reset, then no buttons for 200 cycles -> ena=1, load=0, blink_mask=0 throughout.
- Cur digits 1,4,3,7 (14:37); MODE press, INC x10, MODE, INC x25, MODE -> SET_HR seeded 14, hours become 00 (passing the 23->00 wrap), minutes 37->02 (passing the 59->00 wrap); single load pulse with ld=0,0,0,2; ena=1 the cycle after.
- MODE glitch of 1 sample tick -> no state change; a held level for 2 ticks -> exactly one event.
- MODE and INC pressed in the same cycle while in SET_HR -> state moves to SET_MIN and hours stay unchanged.
- In SET_MIN, watch 64 cycles -> blink_mask alternates between 001100 and 000000 every 8 cycles.
- Assert rst while in SET_MIN with edits pending -> immediate RUN, ena=1, no load pulse, ld_*=0.
